// File: rtl/vga_timing_if.sv
// Display-timing bundle carried from vga_timing_gen to the pixel painter and the VGA connector.
// The master side drives counters, strobes and syncs; the slave side only observes them.
interface vga_timing_if;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       vid_on;
  logic       pixel_en;
  logic       hsync;
  logic       vsync;
  logic       frame_start;

  modport master (
    output pixel_x, pixel_y, vid_on, pixel_en, hsync, vsync, frame_start
  );

  modport slave (
    input pixel_x, pixel_y, vid_on, pixel_en, hsync, vsync, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA timing generator: clock divider, horizontal/vertical counters and
// active-low syncs delayed to line up with the downstream registered colour path.
module vga_timing_gen #(
  parameter int PIX_DIV    = 4,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 2
) (
  input  logic         clk,
  input  logic         rst,
  vga_timing_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]       H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0]       V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0]       HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]       HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]       VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]       VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             div_last;
  logic [9:0]       pixel_x_q;
  logic [9:0]       pixel_y_q;
  logic [9:0]       x_nxt;
  logic [9:0]       y_nxt;
  logic             x_wrap;
  logic             y_wrap;
  logic             vid_on_q;
  logic             pixel_en_q;
  logic             frame_start_q;
  logic             hs_raw;
  logic             vs_raw;

  // With PIX_DIV=1 the counter never leaves 0, so every clk is a pixel clk.
  assign div_last = (div_cnt == DIV_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; the reset branch is asynchronous to match the sensitivity list.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_last) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // NOTE: every variable written here gets a value on every path, so no latch is inferred.
  always_comb begin
    x_wrap = (pixel_x_q == H_LAST);
    y_wrap = (pixel_y_q == V_LAST);
    x_nxt  = x_wrap ? '0 : pixel_x_q + 10'd1;
    y_nxt  = pixel_y_q;
    if (x_wrap) begin
      y_nxt = y_wrap ? '0 : pixel_y_q + 10'd1;
    end
  end

  // vid_on is derived from the next counter values so it lands on the same edge as them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      vid_on_q      <= 1'b0;
      pixel_en_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pixel_en_q    <= div_last;
      frame_start_q <= div_last && x_wrap && y_wrap;
      if (div_last) begin
        pixel_x_q <= x_nxt;
        pixel_y_q <= y_nxt;
        vid_on_q  <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
      end
    end
  end

  assign hs_raw = !((pixel_x_q >= HS_START) && (pixel_x_q < HS_END));
  assign vs_raw = !((pixel_y_q >= VS_START) && (pixel_y_q < VS_END));

  // Sync delay line; stages preset to the inactive level so reset never stretches a pulse.
  if (SYNC_DELAY == 0) begin : g_no_delay
    assign vga.hsync = hs_raw;
    assign vga.vsync = vs_raw;
  end else begin : g_delay
    logic [SYNC_DELAY-1:0] hs_pipe;
    logic [SYNC_DELAY-1:0] vs_pipe;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hs_pipe <= '1;
        vs_pipe <= '1;
      end else begin
        hs_pipe[0] <= hs_raw;
        vs_pipe[0] <= vs_raw;
        for (int i = 1; i < SYNC_DELAY; i++) begin
          hs_pipe[i] <= hs_pipe[i-1];
          vs_pipe[i] <= vs_pipe[i-1];
        end
      end
    end

    assign vga.hsync = hs_pipe[SYNC_DELAY-1];
    assign vga.vsync = vs_pipe[SYNC_DELAY-1];
  end

  assign vga.pixel_x     = pixel_x_q;
  assign vga.pixel_y     = pixel_y_q;
  assign vga.vid_on      = vid_on_q;
  assign vga.pixel_en    = pixel_en_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size 640x480 line timing on one instance, and a small
// PIX_DIV=1 / SYNC_DELAY=0 geometry for frame, vsync and mid-frame reset behaviour.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  vga_timing_if if_a ();
  vga_timing_if if_b ();

  vga_timing_gen dut_a (
    .clk (clk),
    .rst (rst_a),
    .vga (if_a)
  );

  // Small geometry: H_TOTAL=16 (sync x=10..12), V_TOTAL=12 (sync y=8..9), 192 clks per frame.
  vga_timing_gen #(
    .PIX_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_DELAY(0)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .vga (if_b)
  );

  typedef struct {
    int cyc;
    int x;
    int y;
    bit vid;
    bit en;
    bit hs;
    bit vs;
    bit fs;
  } vec_t;

  vec_t vecs [15];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc_a  = 0;
  int   cyc_b  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick_a();
    @(posedge clk);
    @(negedge clk);
    cyc_a++;
  endtask

  task automatic tick_b();
    @(posedge clk);
    @(negedge clk);
    cyc_b++;
  endtask

  initial begin
    int   hs_lo, x656_cyc, fall_cyc, vs_bad, fs_cnt;
    int   hs_err, vs_lo, vid_err, pos_err, en_err, range_err, fs_err;
    int   fs_first, fs_second;
    logic hs_prev;

    // Clock counts below are edges since reset release; cycle 0 is the reset state.
    vecs[0]  = '{0,    0,   0, 0, 0, 1, 1, 0};
    vecs[1]  = '{3,    0,   0, 0, 0, 1, 1, 0};
    vecs[2]  = '{4,    1,   0, 1, 1, 1, 1, 0};
    vecs[3]  = '{5,    1,   0, 1, 0, 1, 1, 0};
    vecs[4]  = '{8,    2,   0, 1, 1, 1, 1, 0};
    vecs[5]  = '{2559, 639, 0, 1, 0, 1, 1, 0};
    vecs[6]  = '{2560, 640, 0, 0, 1, 1, 1, 0};
    vecs[7]  = '{2624, 656, 0, 0, 1, 1, 1, 0};
    vecs[8]  = '{2625, 656, 0, 0, 0, 1, 1, 0};
    vecs[9]  = '{2626, 656, 0, 0, 0, 0, 1, 0};
    vecs[10] = '{3007, 751, 0, 0, 0, 0, 1, 0};
    vecs[11] = '{3009, 752, 0, 0, 0, 0, 1, 0};
    vecs[12] = '{3010, 752, 0, 0, 0, 1, 1, 0};
    vecs[13] = '{3199, 799, 0, 0, 0, 1, 1, 0};
    vecs[14] = '{3200, 0,   1, 1, 1, 1, 1, 0};

    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    cyc_a = 0;

    // First line of the full-size instance against the table.
    for (int i = 0; i < 15; i++) begin
      while (cyc_a < vecs[i].cyc) tick_a();
      check($sformatf("a@%0d pixel_x", cyc_a),     if_a.pixel_x,     vecs[i].x);
      check($sformatf("a@%0d pixel_y", cyc_a),     if_a.pixel_y,     vecs[i].y);
      check($sformatf("a@%0d vid_on", cyc_a),      if_a.vid_on,      vecs[i].vid);
      check($sformatf("a@%0d pixel_en", cyc_a),    if_a.pixel_en,    vecs[i].en);
      check($sformatf("a@%0d hsync", cyc_a),       if_a.hsync,       vecs[i].hs);
      check($sformatf("a@%0d vsync", cyc_a),       if_a.vsync,       vecs[i].vs);
      check($sformatf("a@%0d frame_start", cyc_a), if_a.frame_start, vecs[i].fs);
    end

    // Second line: hsync pulse width and its lag behind pixel_x reaching 656.
    hs_lo = 0; x656_cyc = -1; fall_cyc = -1; vs_bad = 0; fs_cnt = 0;
    hs_prev = if_a.hsync;
    while (cyc_a < 6400) begin
      tick_a();
      if (if_a.hsync === 1'b0) hs_lo++;
      if (x656_cyc < 0 && if_a.pixel_x == 10'd656) x656_cyc = cyc_a;
      if (fall_cyc < 0 && hs_prev === 1'b1 && if_a.hsync === 1'b0) fall_cyc = cyc_a;
      if (if_a.vsync !== 1'b1) vs_bad++;
      if (if_a.frame_start !== 1'b0) fs_cnt++;
      hs_prev = if_a.hsync;
    end
    check("a line2 hsync low clks", hs_lo, 384);
    check("a line2 x=656 clk", x656_cyc, 5824);
    check("a line2 hsync fall clk", fall_cyc, 5826);
    check("a line2 vsync glitches", vs_bad, 0);
    check("a line2 frame_start pulses", fs_cnt, 0);
    check("a@6400 pixel_x", if_a.pixel_x, 0);
    check("a@6400 pixel_y", if_a.pixel_y, 2);

    // Small instance: two full frames with immediate (undelayed) syncs.
    @(negedge clk);
    rst_b = 1'b0;
    cyc_b = 0;
    check("b reset pixel_x", if_b.pixel_x, 0);
    check("b reset vid_on", if_b.vid_on, 0);
    check("b reset pixel_en", if_b.pixel_en, 0);
    check("b reset hsync", if_b.hsync, 1);
    check("b reset vsync", if_b.vsync, 1);

    hs_err = 0; vs_lo = 0; vid_err = 0; pos_err = 0; en_err = 0; range_err = 0;
    fs_err = 0; fs_cnt = 0; fs_first = -1; fs_second = -1;
    while (cyc_b < 384) begin
      int ex, ey;
      tick_b();
      ex = cyc_b % 16;
      ey = (cyc_b / 16) % 12;
      if (if_b.pixel_x != 10'(ex) || if_b.pixel_y != 10'(ey)) pos_err++;
      if (if_b.pixel_x > 10'd15 || if_b.pixel_y > 10'd11) range_err++;
      if (if_b.pixel_en !== 1'b1) en_err++;
      if (if_b.vid_on !== ((ex < 8) && (ey < 6))) vid_err++;
      if (if_b.vid_on === 1'b1 && if_b.pixel_y >= 10'd6) vid_err++;
      if (if_b.hsync !== !((if_b.pixel_x >= 10'd10) && (if_b.pixel_x < 10'd13))) hs_err++;
      if (if_b.vsync === 1'b0) vs_lo++;
      if (if_b.frame_start === 1'b1) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = cyc_b;
        else if (fs_second < 0) fs_second = cyc_b;
      end
      if (if_b.frame_start === 1'b1 && (if_b.pixel_x != 10'd0 || if_b.pixel_y != 10'd0)) fs_err++;
    end
    check("b counter position errors", pos_err, 0);
    check("b counter range errors", range_err, 0);
    check("b pixel_en gaps", en_err, 0);
    check("b vid_on errors", vid_err, 0);
    check("b hsync vs raw errors", hs_err, 0);
    check("b vsync low clks (2 frames)", vs_lo, 64);
    check("b frame_start count", fs_cnt, 2);
    check("b first frame_start clk", fs_first, 192);
    check("b second frame_start clk", fs_second, 384);
    check("b frame_start off origin", fs_err, 0);

    // Mid-frame reset while both syncs are active.
    while (cyc_b < 384 + 139) tick_b();
    check("b pre-rst pixel_x", if_b.pixel_x, 11);
    check("b pre-rst pixel_y", if_b.pixel_y, 8);
    check("b pre-rst hsync", if_b.hsync, 0);
    check("b pre-rst vsync", if_b.vsync, 0);
    #1 rst_b = 1'b1;
    #1;
    check("b mid-rst pixel_x", if_b.pixel_x, 0);
    check("b mid-rst pixel_y", if_b.pixel_y, 0);
    check("b mid-rst vid_on", if_b.vid_on, 0);
    check("b mid-rst hsync", if_b.hsync, 1);
    check("b mid-rst vsync", if_b.vsync, 1);
    @(negedge clk);
    rst_b = 1'b0;
    cyc_b = 0;
    tick_b();
    check("b post-rst@1 pixel_x", if_b.pixel_x, 1);
    check("b post-rst@1 pixel_y", if_b.pixel_y, 0);
    check("b post-rst@1 vid_on", if_b.vid_on, 1);
    check("b post-rst@1 frame_start", if_b.frame_start, 0);
    while (cyc_b < 10) tick_b();
    check("b post-rst@10 pixel_x", if_b.pixel_x, 10);
    check("b post-rst@10 hsync", if_b.hsync, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
